// File: rtl/game_sequencer_fsm_if.sv
// Handshake bundle between the board-side logic and the game sequencer.
// The master side owns the keys and the pattern/board buses; the slave side
// (the sequencer) drives the datapath load strobes and the game status.
interface game_sequencer_fsm_if;

   logic       go;
   logic       submit;
   logic [8:0] pattern;
   logic [8:0] board;

   logic       ld_start;
   logic       ld_level;
   logic       ld_read;
   logic       ld_reset;
   logic       ld_input;
   logic       ld_evaluate;
   logic [1:0] level;
   logic       win;
   logic       lose;
   logic [3:0] score;

   modport master (
      output go,
      output submit,
      output pattern,
      output board,
      input  ld_start,
      input  ld_level,
      input  ld_read,
      input  ld_reset,
      input  ld_input,
      input  ld_evaluate,
      input  level,
      input  win,
      input  lose,
      input  score
   );

   modport slave (
      input  go,
      input  submit,
      input  pattern,
      input  board,
      output ld_start,
      output ld_level,
      output ld_read,
      output ld_reset,
      output ld_input,
      output ld_evaluate,
      output level,
      output win,
      output lose,
      output score
   );

endinterface

// File: rtl/game_sequencer_fsm.sv
// Top-level controller for the 3x3 grid memory game.
// Sequences idle -> level clear -> show pattern -> blank board -> player entry ->
// evaluate, advancing a level on a full 9-bit match and ending in win or lose.
// Each timed display phase lasts DWELL_CYCLES clocks so the datapath sweep completes.
// Optional feature: define INPUT_TIMEOUT_EN to end the entry phase automatically
// after TIMEOUT_CYCLES clocks without a submit; by default entry waits forever.
module game_sequencer_fsm #(
   parameter int unsigned DWELL_CYCLES   = 10000,
   parameter int unsigned MAX_LEVEL      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input logic                 CLOCK_50,
   input logic                 reset,
   game_sequencer_fsm_if.slave bus
);

   // One counter serves both the display dwell and the entry timeout.
   localparam int unsigned CNT_RANGE = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES
                                                                       : TIMEOUT_CYCLES;
   localparam int unsigned DW = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [1:0]    LEVEL_LAST = 2'(MAX_LEVEL);
`ifdef INPUT_TIMEOUT_EN
   localparam logic [DW-1:0] TIMEOUT_LAST = DW'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEVEL,
      S_SHOW,
      S_CLEAR,
      S_INPUT,
      S_EVAL,
      S_WIN,
      S_LOSE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    level_q, level_d;
   logic [3:0]    score_q, score_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [8:0]    pat_q, pat_d;
   logic [8:0]    entry_q, entry_d;
   logic          go_q;
   logic          sub_q;

   logic          go_rise;
   logic          sub_rise;
   logic          dwell_done;
   logic          match;

   // Key edge events: one press yields exactly one event.
   assign go_rise    = bus.go & ~go_q;
   assign sub_rise   = bus.submit & ~sub_q;
   assign dwell_done = (dwell_q == DWELL_LAST);
   assign match      = (entry_q == pat_q);

   // Next-state, counter and capture logic.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      score_d = score_q;
      dwell_d = dwell_q;
      pat_d   = pat_q;
      entry_d = entry_q;

      unique case (state_q)
         S_IDLE: begin
            if (go_rise) begin
               state_d = S_LEVEL;
            end
         end

         S_LEVEL: begin
            pat_d   = bus.pattern;
            dwell_d = '0;
            state_d = S_SHOW;
         end

         S_SHOW: begin
            if (dwell_done) begin
               dwell_d = '0;
               state_d = S_CLEAR;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         S_CLEAR: begin
            if (dwell_done) begin
               dwell_d = '0;
               state_d = S_INPUT;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         S_INPUT: begin
`ifdef INPUT_TIMEOUT_EN
            // A submit and an expiring timer on the same cycle do the same thing.
            if (sub_rise || (dwell_q == TIMEOUT_LAST)) begin
               entry_d = bus.board;
               dwell_d = '0;
               state_d = S_EVAL;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
`else
            if (sub_rise) begin
               entry_d = bus.board;
               dwell_d = '0;
               state_d = S_EVAL;
            end
`endif
         end

         S_EVAL: begin
            if (dwell_done) begin
               dwell_d = '0;
               if (match) begin
                  if (score_q != 4'd15) begin
                     score_d = score_q + 4'd1;
                  end
                  if (level_q == LEVEL_LAST) begin
                     state_d = S_WIN;
                  end else begin
                     level_d = level_q + 2'd1;
                     state_d = S_LEVEL;
                  end
               end else begin
                  state_d = S_LOSE;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         S_WIN, S_LOSE: begin
            if (go_rise) begin
               level_d = '0;
               score_d = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= '0;
         score_q <= '0;
         dwell_q <= '0;
         pat_q   <= '0;
         entry_q <= '0;
         go_q    <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         score_q <= score_d;
         dwell_q <= dwell_d;
         pat_q   <= pat_d;
         entry_q <= entry_d;
         go_q    <= bus.go;
         sub_q   <= bus.submit;
      end
   end

   // Moore output decode: at most one load strobe per state, none in win/lose.
   always_comb begin
      bus.ld_start    = 1'b0;
      bus.ld_level    = 1'b0;
      bus.ld_read     = 1'b0;
      bus.ld_reset    = 1'b0;
      bus.ld_input    = 1'b0;
      bus.ld_evaluate = 1'b0;
      bus.win         = 1'b0;
      bus.lose        = 1'b0;

      unique case (state_q)
         S_IDLE:  bus.ld_start    = 1'b1;
         S_LEVEL: bus.ld_level    = 1'b1;
         S_SHOW:  bus.ld_read     = 1'b1;
         S_CLEAR: bus.ld_reset    = 1'b1;
         S_INPUT: bus.ld_input    = 1'b1;
         S_EVAL:  bus.ld_evaluate = 1'b1;
         S_WIN:   bus.win         = 1'b1;
         S_LOSE:  bus.lose        = 1'b1;
         default: bus.ld_start    = 1'b0;
      endcase
   end

   assign bus.level = level_q;
   assign bus.score = score_q;

endmodule
